// File: rtl/mod96_pkg.sv
// Shared constants, state encoding and helpers for the 96-to-64-bit reduction
// modulo P = 2^64 - 2^32 + 1.
package mod96_pkg;

  localparam int D_WIDTH = 96;
  localparam int P_WIDTH = 64;
  localparam int T_WIDTH = 66;

  // The fold identity 2^64 == 2^32 - 1 (mod P) holds only for this modulus.
  localparam logic [P_WIDTH-1:0] P_MOD = 64'hFFFF_FFFF_0000_0001;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADD  = 3'd1;
  localparam logic [2:0] SUB  = 3'd2;
  localparam logic [2:0] CORR = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = IDLE,
    ST_ADD  = ADD,
    ST_SUB  = SUB,
    ST_CORR = CORR,
    ST_DONE = DONE
  } state_e;

  function automatic logic [T_WIDTH-1:0] zext64(input logic [63:0] v);
    return {{(T_WIDTH-64){1'b0}}, v};
  endfunction

  function automatic logic [T_WIDTH-1:0] zext32(input logic [31:0] v);
    return {{(T_WIDTH-32){1'b0}}, v};
  endfunction

endpackage

// File: rtl/mod96_addsub.sv
// Shared 66-bit adder/subtractor: sum = a + (sub ? ~b : b) + sub.
// When subtracting, carry-out high means a >= b (no borrow).
module mod96_addsub
  import mod96_pkg::*;
(
  input  logic [T_WIDTH-1:0] a_in,
  input  logic [T_WIDTH-1:0] b_in,
  input  logic               sub_in,
  output logic [T_WIDTH-1:0] sum_out,
  output logic               cout_out
);

  logic [T_WIDTH-1:0] b_eff;
  logic [T_WIDTH:0]   full;

  always_comb begin
    b_eff = sub_in ? ~b_in : b_in;
    full  = {1'b0, a_in} + {1'b0, b_eff} + {{T_WIDTH{1'b0}}, sub_in};
  end

  assign sum_out  = full[T_WIDTH-1:0];
  assign cout_out = full[T_WIDTH];

endmodule

// File: rtl/mod96_reduce_ctrl.sv
// Sequencer for A mod P with A 96 bits: fold, subtract d, one conditional correction.
// Optional build macro MOD96_REDUCE_PERF_CNT_EN adds a 32-bit completed-result counter.
module mod96_reduce_ctrl
  import mod96_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_in,
  output logic               in_ready_out,
  input  logic [D_WIDTH-1:0] A_in,
  output logic               out_valid_out,
  input  logic               out_ready_in,
  output logic [P_WIDTH-1:0] R_out,
`ifdef MOD96_REDUCE_PERF_CNT_EN
  output logic [31:0]        op_cnt_out,
`endif
  output logic               busy_out
);

  state_e             state_q, state_d;
  logic [T_WIDTH-1:0] t_q, t_d;
  logic [31:0]        d_reg_q, d_reg_d;
  logic [63:0]        ef_reg_q, ef_reg_d;
  logic [P_WIDTH-1:0] r_q, r_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [T_WIDTH-1:0] au_a, au_b, au_sum;
  logic               au_sub, au_cout;
  logic               accept, out_fire;

  mod96_addsub u_addsub (
    .a_in     (au_a),
    .b_in     (au_b),
    .sub_in   (au_sub),
    .sum_out  (au_sum),
    .cout_out (au_cout)
  );

  assign in_ready_out = (state_q == ST_IDLE);
  assign accept       = in_valid_in & in_ready_out;
  assign out_fire     = out_valid_q & out_ready_in;

  always_comb begin
    au_a   = t_q;
    au_b   = '0;
    au_sub = 1'b0;
    unique case (state_q)
      ST_ADD: begin
        au_a   = zext64(ef_reg_q);
        au_b   = zext64({d_reg_q, 32'h0});
        au_sub = 1'b0;
      end
      ST_SUB: begin
        au_a   = t_q;
        au_b   = zext32(d_reg_q);
        au_sub = 1'b1;
      end
      ST_CORR: begin
        au_a   = t_q;
        au_b   = zext64(P_MOD);
        au_sub = 1'b1;
      end
      default: begin
        au_a   = t_q;
        au_b   = '0;
        au_sub = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    d_reg_d  = d_reg_q;
    ef_reg_d = ef_reg_q;
    r_d      = r_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ef_reg_d = A_in[63:0];
          d_reg_d  = A_in[95:64];
          state_d  = ST_ADD;
        end
      end
      ST_ADD: begin
        t_d     = au_sum;
        state_d = ST_SUB;
      end
      ST_SUB: begin
        t_d     = au_sum;
        state_d = ST_CORR;
      end
      ST_CORR: begin
        // After SUB t < 2P, so one conditional subtract lands in [0, P).
        if (au_cout) begin
          t_d = au_sum;
        end
        r_d     = t_d[P_WIDTH-1:0];
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready_in) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      d_reg_q     <= '0;
      ef_reg_q    <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      d_reg_q     <= d_reg_d;
      ef_reg_q    <= ef_reg_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid_out = out_valid_q;
  assign R_out         = r_q;
  assign busy_out      = busy_q;

`ifdef MOD96_REDUCE_PERF_CNT_EN
  logic [31:0] op_cnt_q, op_cnt_d;

  always_comb begin
    op_cnt_d = op_cnt_q;
    if (out_fire) begin
      op_cnt_d = op_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt_q <= '0;
    end else begin
      op_cnt_q <= op_cnt_d;
    end
  end

  assign op_cnt_out = op_cnt_q;
`else
  logic unused_fire;
  assign unused_fire = out_fire;
`endif

endmodule

// File: tb/tb_mod96_reduce_ctrl.sv
// Self-checking bench for mod96_reduce_ctrl: vector table, corner sequences,
// and randomized operands against a plain A % P reference.
module tb_mod96_reduce_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_in;
  logic        in_ready_out;
  logic [95:0] A_in;
  logic        out_valid_out;
  logic        out_ready_in;
  logic [63:0] R_out;
  logic        busy_out;
`ifdef MOD96_REDUCE_PERF_CNT_EN
  logic [31:0] op_cnt_out;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  localparam logic [95:0] P96 = {32'h0, 64'hFFFF_FFFF_0000_0001};

  mod96_reduce_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_in   (in_valid_in),
    .in_ready_out  (in_ready_out),
    .A_in          (A_in),
    .out_valid_out (out_valid_out),
    .out_ready_in  (out_ready_in),
    .R_out         (R_out),
`ifdef MOD96_REDUCE_PERF_CNT_EN
    .op_cnt_out    (op_cnt_out),
`endif
    .busy_out      (busy_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] a;
    logic [63:0] r;
    string       name;
  } vec_t;

  function automatic logic [63:0] model(input logic [95:0] a);
    logic [95:0] m;
    m = a % P96;
    return m[63:0];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Waits for out_valid after an accept; caller is at cycle 1. Returns latency or -1.
  task automatic wait_result(input string nm, output int lat);
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      if (out_valid_out) begin
        lat = k;
        break;
      end
      chk({nm, "_rdy_busy"}, {in_ready_out, busy_out}, 2'b01);
      A_in = rnd96();
      step();
    end
    chk({nm, "_latency"}, lat, 4);
  endtask

  task automatic do_op(input logic [95:0] a, input logic [63:0] exp, input string nm,
                       input int hold);
    int w;
    int lat;
    w = 0;
    while (!in_ready_out && w < 10) begin
      step();
      w++;
    end
    chk({nm, "_idle"}, in_ready_out, 1'b1);
    in_valid_in = 1'b1;
    A_in        = a;
    step();
    in_valid_in = 1'b0;
    wait_result(nm, lat);
    chk({nm, "_R"}, R_out, exp);
    for (int h = 0; h < hold; h++) begin
      out_ready_in = 1'b0;
      step();
      chk({nm, "_hold"}, {out_valid_out, R_out}, {1'b1, exp});
    end
    out_ready_in = 1'b1;
    step();
    out_ready_in = 1'b0;
    exp_cnt++;
    chk({nm, "_release"}, {out_valid_out, in_ready_out, busy_out}, 3'b010);
  endtask

  vec_t vecs[$];

  initial begin
    logic [95:0] a;
    int          lat;

    vecs.push_back('{96'h0, 64'h0, "zero"});
    vecs.push_back('{96'h1_0000_0000_0000_0000, 64'h0000_0000_FFFF_FFFF, "fold_only"});
    vecs.push_back('{96'h0_FFFF_FFFF_0000_0001, 64'h0, "eq_p"});
    vecs.push_back('{96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFE_FFFF_FFFF, "max"});
    vecs.push_back('{96'h1, 64'h1, "one"});
    vecs.push_back('{96'h0_FFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, "p_minus1"});
    vecs.push_back('{96'h0_FFFF_FFFF_0000_0006, 64'h5, "p_plus5"});
    vecs.push_back('{96'h1_0000_0000_0000_0005, 64'h0000_0001_0000_0004, "fold_plus5"});
    vecs.push_back('{96'h0_FFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFE, "ef_all1"});

    rst          = 1'b1;
    in_valid_in  = 1'b0;
    out_ready_in = 1'b0;
    A_in         = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset_state", {in_ready_out, out_valid_out, busy_out, R_out}, {3'b100, 64'h0});
`ifdef MOD96_REDUCE_PERF_CNT_EN
    chk("reset_cnt", op_cnt_out, 32'h0);
`endif

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].r, vecs[i].name, i % 3);
    end

    // Backpressure in DONE with in_valid held high and A_in changing.
    in_valid_in = 1'b1;
    A_in        = 96'h1_0000_0000_0000_0000;
    step();
    wait_result("bp", lat);
    chk("bp_R", R_out, 64'h0000_0000_FFFF_FFFF);
    for (int h = 0; h < 3; h++) begin
      A_in = rnd96();
      step();
      chk("bp_hold", {out_valid_out, in_ready_out, R_out}, {2'b10, 64'h0000_0000_FFFF_FFFF});
    end
    A_in         = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    out_ready_in = 1'b1;
    step();
    exp_cnt++;
    out_ready_in = 1'b0;
    chk("bp_idle", {out_valid_out, in_ready_out}, 2'b01);
    step();
    in_valid_in = 1'b0;
    wait_result("bp_next", lat);
    chk("bp_next_R", R_out, 64'hFFFF_FFFE_FFFF_FFFF);
    out_ready_in = 1'b1;
    step();
    exp_cnt++;
    out_ready_in = 1'b0;
`ifdef MOD96_REDUCE_PERF_CNT_EN
    chk("cnt_before_rst", op_cnt_out, exp_cnt);
`endif

    // Reset while in SUB: result discarded.
    in_valid_in = 1'b1;
    A_in        = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    step();
    in_valid_in = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst     = 1'b0;
    exp_cnt = 0;
    chk("rst_mid", {in_ready_out, out_valid_out, busy_out, R_out}, {3'b100, 64'h0});
`ifdef MOD96_REDUCE_PERF_CNT_EN
    chk("rst_mid_cnt", op_cnt_out, 32'h0);
`endif
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rst_discard", {out_valid_out, in_ready_out}, 2'b01);
    end

    // Reset has priority over an accept in IDLE.
    rst         = 1'b1;
    in_valid_in = 1'b1;
    A_in        = 96'h5;
    step();
    rst         = 1'b0;
    in_valid_in = 1'b0;
    chk("rst_prio", {in_ready_out, busy_out}, 2'b10);
    do_op(96'h1_0000_0000_0000_0000, 64'h0000_0000_FFFF_FFFF, "after_rst", 0);

    for (int n = 0; n < 150; n++) begin
      a = rnd96();
      case ($urandom_range(0, 4))
        0: a[95:64] = 32'hFFFF_FFFF;
        1: a[63:0]  = 64'hFFFF_FFFF_0000_0000 + 64'($urandom_range(0, 3));
        default: ;
      endcase
      do_op(a, model(a), "rand", $urandom_range(0, 2));
    end

`ifdef MOD96_REDUCE_PERF_CNT_EN
    chk("cnt_final", op_cnt_out, exp_cnt);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod96_reduce_ctrl.md
Name: mod96_reduce_ctrl

Overview:
- Sequencing controller for the 96-bit to 64-bit modular reduction over P = 2^64 - 2^32 + 1.
- Accepts a 96-bit operand A = d*2^64 + e*2^32 + f through a valid/ready handshake.
- Steps one shared 66-bit add/sub unit through a fixed schedule: fold, subtract d, one conditional correction.
- Returns R = A mod P through a valid/ready output; sits between the multiplier product stage and the butterfly datapath.

Parameters:
D_WIDTH, 96, input operand width
P_WIDTH, 64, modulus/result width
P_MOD, 64'hFFFFFFFF00000001, modulus; the fold identity holds only for this value

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid_in  in  1  operand valid
in_ready_out  out  1  controller can accept an operand
A_in  in  D_WIDTH  operand; sampled only on the accept cycle
out_valid_out  out  1  result valid
out_ready_in  in  1  downstream accepts result
R_out  out  P_WIDTH  reduced result
busy_out  out  1  high in any state other than IDLE

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset values:
  - state = IDLE
  - in_ready_out = 1
  - out_valid_out = 0
  - R_out = 0
  - busy_out = 0
  - internal t (66-bit), d_reg (32-bit) and ef_reg (64-bit) = 0
- in_ready_out = (state == IDLE), driven combinationally from state.
- Accept occurs when in_valid_in & in_ready_out. On accept:
  - ef_reg <= A_in[63:0]
  - d_reg <= A_in[95:64]
  - next state ADD
- ADD: t <= ef_reg + {d_reg, 32'h0}, 65-bit result zero-extended to 66 bits. Next state SUB.
- SUB: t <= t + ~{34'h0, d_reg} + 1, i.e. t - d. No underflow is possible because d*2^32 >= d. Next state CORR.
- CORR:
  - If t >= P_MOD, then t <= t - P_MOD; otherwise t is held.
  - A single correction always suffices: after SUB, t <= 2^65 - 2^33 < 2*P_MOD.
  - Next state DONE.
- DONE:
  - out_valid_out = 1; R_out = t[63:0].
  - Both are held stable while out_ready_in = 0.
  - On out_ready_in = 1, next state IDLE and out_valid_out drops on the following cycle.
- Latency:
  - Accept on cycle 0; out_valid_out rises on cycle 4.
  - One result per 5 cycles at minimum, since there is no overlap and IDLE is required before the next accept.
- Boundaries:
  - in_valid_in outside IDLE: ignored, A_in not sampled, no queuing.
  - Output handshake completes in the DONE cycle with in_valid_in high: not accepted until the next cycle, when state is IDLE.
  - rst in any state: forces all reset values on the next edge. Any in-flight result is discarded and never presented.
  - rst takes priority over accept and over out_ready_in.

Optional Feature:
- Macro: MOD96_REDUCE_PERF_CNT_EN.
- When defined:
  - Adds output op_cnt_out (32-bit), reset 0.
  - Increments on each completed output handshake (out_valid_out & out_ready_in) and wraps from 32'hFFFFFFFF to 0.
- When not defined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package mod96_pkg:
  - state encoding localparams IDLE=0, ADD=1, SUB=2, CORR=3, DONE=4 (3-bit)
  - P_MOD constant
  - width constants D_WIDTH, P_WIDTH, T_WIDTH=66
- One sub-module, mod96_addsub: combinational 66-bit a + (sub ? ~b : b) + sub, with carry-out. The controller drives its operand muxes per state.

Test Plan:
- Zero operand: A=0, accept cycle 0 -> out_valid_out rises cycle 4, R_out=0; in_ready_out low on cycles 1-4.
- Fold only: A=96'h1_0000000000000000 (2^64) -> R_out=64'h00000000FFFFFFFF.
- Correction path: A=96'h0_FFFFFFFF00000001 (=P) -> CORR subtracts once, R_out=0.
- Max operand: A=96'hFFFFFFFF_FFFFFFFF_FFFFFFFF -> R_out=64'hFFFFFFFEFFFFFFFF, i.e. P-2.
- Backpressure: hold out_ready_in=0 for 3 cycles in DONE with in_valid_in=1 and a changing A_in -> R_out and out_valid_out stable, in_ready_out=0, no accept. On release, IDLE next cycle, then the new accept.
- Reset mid-op: assert rst in SUB -> next cycle state IDLE, out_valid_out=0, in_ready_out=1, R_out=0. A following A=2^64 still yields 64'h00000000FFFFFFFF. With MOD96_REDUCE_PERF_CNT_EN defined, op_cnt_out counts only completed handshakes and is 0 after reset.
